framebuf_scan_reader: RTL and testbench

//  Avalon-MM read master that scans one frame out of the 16-bit on-chip frame buffer
//  (4096 words, Avalon slave) and presents it as a ready/valid pixel stream to the LED

---
 rtl/framebuf_pkg.sv | 19 +
 rtl/framebuf_pix_fifo.sv | 71 +++++++
 rtl/framebuf_scan_reader.sv | 169 ++++++++++++++++
 tb/tb_framebuf_scan_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuf_pkg.sv
// Shared types and constants for the frame-buffer scan-out path.
//   scan_state_t      : scan reader FSM states
//   FB_WORDS          : frame-buffer depth in 16-bit words
//   FB_DATA_W         : frame-buffer word width
//   FB_BYTES_PER_WORD : byte-address stride between consecutive words
package framebuf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam int unsigned FB_WORDS          = 4096;
    localparam int unsigned FB_DATA_W         = 16;
    localparam int unsigned FB_BYTES_PER_WORD = 2;

endpackage

// File: rtl/framebuf_pix_fifo.sv
// Synchronous pixel FIFO with flop storage; head word is read straight from the
// storage flops so o_data is registered.
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_push, i_data    write strobe and word
//   i_pop             consume head word (ignored when empty)
//   o_data            head word, valid while ~o_empty
//   o_count           number of stored words (0..DEPTH)
//   o_empty, o_full   registered status flags
module framebuf_pix_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_push,
    input  logic [DATA_W-1:0]         i_data,
    input  logic                      i_pop,
    output logic [DATA_W-1:0]         o_data,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_empty,
    output logic                      o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_empty;
    logic              r_full;

    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_nxt;

    // A push into a full FIFO is only honoured when a pop frees a slot the same cycle.
    assign w_pop       = i_pop & ~r_empty;
    assign w_push      = i_push & (~r_full | w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Pointers, occupancy and flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Storage; contents need no reset, the flags gate them.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/framebuf_scan_reader.sv
// Avalon-MM read master that scans one frame out of the frame buffer and streams
// it to the LED driver as ready/valid pixels with sop/eop framing.
// Ports:
//   i_clk, i_reset                      clock, synchronous active-high reset
//   i_start, i_base_addr, i_num_words   frame request (sampled in IDLE only)
//   o_avm_address/read/byteenable       Avalon read request
//   i_avm_waitrequest                   slave stall
//   i_avm_readdata/readdatavalid        in-order read responses
//   o_pix_data/valid/sop/eop, i_pix_ready  pixel stream to sink
//   o_busy, o_frame_done                scan status
module framebuf_scan_reader
    import framebuf_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned CNT_W      = 13,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [CNT_W-1:0]      i_num_words,
    output logic [ADDR_W-1:0]     o_avm_address,
    output logic                  o_avm_read,
    output logic [1:0]            o_avm_byteenable,
    input  logic                  i_avm_waitrequest,
    input  logic [FB_DATA_W-1:0]  i_avm_readdata,
    input  logic                  i_avm_readdatavalid,
    output logic [FB_DATA_W-1:0]  o_pix_data,
    output logic                  o_pix_valid,
    input  logic                  i_pix_ready,
    output logic                  o_pix_sop,
    output logic                  o_pix_eop,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int unsigned OUT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRED_W = OUT_W + 1;

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;

    logic                 r_avm_read;
    logic                 w_avm_read_nxt;
    logic [ADDR_W-1:0]    r_addr;
    logic [CNT_W-1:0]     r_num;
    logic [CNT_W-1:0]     r_issued;
    logic [CNT_W-1:0]     r_popped;
    logic [OUT_W-1:0]     r_outstanding;
    logic                 r_busy;
    logic                 r_frame_done;

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_start_ok;
    logic                 w_last_issue;
    logic                 w_last_pop;
    logic [OUT_W-1:0]     w_outstanding_nxt;
    logic [OUT_W-1:0]     w_fifo_count;
    logic [OUT_W-1:0]     w_fifo_count_nxt;
    logic [CRED_W-1:0]    w_credit_nxt;
    logic [FB_DATA_W-1:0] w_fifo_data;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;

    assign w_accept     = r_avm_read & ~i_avm_waitrequest;
    // A response with nothing outstanding is a leftover from before a reset.
    assign w_push       = i_avm_readdatavalid & (r_outstanding != '0);
    assign w_pop        = ~w_fifo_empty & i_pix_ready;
    assign w_start_ok   = i_start & (r_state == IDLE);
    assign w_last_issue = w_accept & (CNT_W'(r_issued + 1'b1) == r_num);
    assign w_last_pop   = w_pop & (CNT_W'(r_popped + 1'b1) == r_num);

    // Credit seen by the request issued next cycle: in-flight reads plus buffered words.
    assign w_outstanding_nxt = r_outstanding + OUT_W'(w_accept) - OUT_W'(w_push);
    assign w_fifo_count_nxt  = w_fifo_count + OUT_W'(w_push) - OUT_W'(w_pop);
    assign w_credit_nxt      = CRED_W'(w_outstanding_nxt) + CRED_W'(w_fifo_count_nxt);

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and next read request.
    always_comb begin
        w_state_nxt    = r_state;
        w_avm_read_nxt = 1'b0;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = (i_num_words == '0) ? DONE : ISSUE;
            ISSUE:   if (w_last_issue) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_pop) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // A stalled request is held; otherwise request again only while credit remains.
        if (r_avm_read && i_avm_waitrequest) begin
            w_avm_read_nxt = 1'b1;
        end else if ((w_state_nxt == ISSUE) && (w_credit_nxt < CRED_W'(FIFO_DEPTH))) begin
            w_avm_read_nxt = 1'b1;
        end
    end

    // Request, counters and status registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_avm_read    <= 1'b0;
            r_addr        <= '0;
            r_num         <= '0;
            r_issued      <= '0;
            r_popped      <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_avm_read    <= w_avm_read_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_frame_done  <= (r_state == DONE);
            if (w_start_ok) begin
                r_addr   <= i_base_addr;
                r_num    <= i_num_words;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_accept) begin
                    r_addr   <= r_addr + ADDR_W'(FB_BYTES_PER_WORD);
                    r_issued <= CNT_W'(r_issued + 1'b1);
                end
                if (w_pop) r_popped <= CNT_W'(r_popped + 1'b1);
            end
        end
    end

    framebuf_pix_fifo #(
        .DATA_W (FB_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (i_avm_readdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign o_avm_address    = r_addr;
    assign o_avm_read       = r_avm_read;
    assign o_avm_byteenable = 2'b11;
    assign o_pix_data       = w_fifo_data;
    assign o_pix_valid      = ~w_fifo_empty;
    assign o_pix_sop        = ~w_fifo_empty & (r_popped == '0);
    assign o_pix_eop        = ~w_fifo_empty & (r_popped == CNT_W'(r_num - 1'b1));
    assign o_busy           = r_busy;
    assign o_frame_done     = r_frame_done;

    // The credit rule keeps the FIFO from ever overflowing.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_push && !w_pop && w_fifo_full));

    a_num_range: assert property (@(posedge i_clk) disable iff (i_reset)
        !w_start_ok || (32'(i_num_words) <= FB_WORDS));

endmodule

// File: tb/tb_framebuf_scan_reader.sv
// Directed bench for framebuf_scan_reader: Avalon slave model with configurable
// latency/stall, pixel sink with configurable ready, linear test sequence.
module tb_framebuf_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base;
    logic [12:0] num;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [1:0]  avm_be;
    logic        avm_wr    = 1'b0;
    logic [15:0] avm_rdata = 16'h0;
    logic        avm_rdv   = 1'b0;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_sop;
    logic        pix_eop;
    logic        busy;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // Knobs written only by the stimulus block.
    int lat      = 1;
    int wr_pct   = 0;
    int rdy_mode = 0;

    // Logs written only by the slave/sink block.
    int          cyc = 0;
    logic [31:0] acc_addr[$];
    logic [15:0] rsp_data[$];
    int          rsp_due[$];
    int          rsp_cnt  = 0;
    int          max_out  = 0;
    int          stab_err = 0;
    logic [15:0] rx_data[$];
    logic        rx_sop[$];
    logic        rx_eop[$];
    int          fd_cnt = 0;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr    = 32'h0;

    framebuf_scan_reader dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_start             (start),
        .i_base_addr         (base),
        .i_num_words         (num),
        .o_avm_address       (avm_address),
        .o_avm_read          (avm_read),
        .o_avm_byteenable    (avm_be),
        .i_avm_waitrequest   (avm_wr),
        .i_avm_readdata      (avm_rdata),
        .i_avm_readdatavalid (avm_rdv),
        .o_pix_data          (pix_data),
        .o_pix_valid         (pix_valid),
        .i_pix_ready         (pix_ready),
        .o_pix_sop           (pix_sop),
        .o_pix_eop           (pix_eop),
        .o_busy              (busy),
        .o_frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    // Frame-buffer content: word index tagged with 0xC in the top nibble.
    function automatic logic [15:0] fb_word(input logic [31:0] a);
        return {4'hC, a[12:1]};
    endfunction

    // Slave and sink act at the falling edge; their decisions take effect at the next rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        avm_rdv = 1'b0;
        if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            avm_rdata = rsp_data.pop_front();
            void'(rsp_due.pop_front());
            avm_rdv = 1'b1;
            rsp_cnt = rsp_cnt + 1;
        end
        if (prev_pending && (!avm_read || avm_address != prev_addr)) stab_err = stab_err + 1;
        avm_wr = (wr_pct >= 100) || (int'($urandom_range(99)) < wr_pct);
        if (avm_read && !avm_wr && !rst) begin
            acc_addr.push_back(avm_address);
            rsp_data.push_back(fb_word(avm_address));
            rsp_due.push_back(cyc + lat);
            if (acc_addr.size() - rsp_cnt > max_out) max_out = acc_addr.size() - rsp_cnt;
        end
        prev_pending = avm_read && avm_wr && !rst;
        prev_addr    = avm_address;
        case (rdy_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ($urandom_range(1) == 1);
            default: pix_ready = 1'b0;
        endcase
        if (pix_valid && pix_ready && !rst) begin
            rx_data.push_back(pix_data);
            rx_sop.push_back(pix_sop);
            rx_eop.push_back(pix_eop);
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [12:0] n);
        base  = b;
        num   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            tick();
            if (frame_done) found = 1'b1;
        end
        chk({tag, " frame_done seen"}, 32'(found), 32'd1);
        chk({tag, " busy low at done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, " done is one pulse"}, 32'(frame_done), 32'd0);
        tick();
    endtask

    // Compare everything logged since the snapshot against the expected frame.
    task automatic check_frame(input string tag, input logic [31:0] b, input int n,
                               input int acc0, input int rx0, input int fd0);
        int bad_addr;
        int bad_data;
        int bad_flag;
        bad_addr = 0;
        bad_data = 0;
        bad_flag = 0;
        chk({tag, " reads issued"}, 32'(acc_addr.size() - acc0), 32'(n));
        for (int i = 0; i < n && (acc0 + i) < acc_addr.size(); i++)
            if (acc_addr[acc0 + i] !== b + 32'(2 * i)) bad_addr++;
        chk({tag, " bad addresses"}, 32'(bad_addr), 32'd0);
        chk({tag, " words received"}, 32'(rx_data.size() - rx0), 32'(n));
        for (int i = 0; i < n && (rx0 + i) < rx_data.size(); i++) begin
            if (rx_data[rx0 + i] !== fb_word(b + 32'(2 * i))) bad_data++;
            if (rx_sop[rx0 + i] !== (i == 0))     bad_flag++;
            if (rx_eop[rx0 + i] !== (i == n - 1)) bad_flag++;
        end
        chk({tag, " bad data words"}, 32'(bad_data), 32'd0);
        chk({tag, " bad sop/eop"}, 32'(bad_flag), 32'd0);
        chk({tag, " frame_done count"}, 32'(fd_cnt - fd0), 32'd1);
    endtask

    initial begin
        int acc0;
        int rx0;
        int fd0;
        int seen_v;
        int seen_b;
        int seen_r;
        logic ok;

        rst = 1'b1; start = 1'b0; base = 32'h0; num = 13'd0;
        repeat (3) tick();
        chk("rst avm_read",   32'(avm_read),   32'd0);
        chk("rst avm_address", avm_address,    32'h0);
        chk("rst pix_valid",  32'(pix_valid),  32'd0);
        chk("rst sop/eop",    32'({pix_sop, pix_eop}), 32'd0);
        chk("rst busy",       32'(busy),       32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("byteenable",     32'(avm_be),     32'd3);
        rst = 1'b0;
        tick();

        // 1: 16 words from 0, latency 1, no stalls.
        acc0 = acc_addr.size(); rx0 = rx_data.size(); fd0 = fd_cnt;
        pulse_start(32'h0, 13'd16);
        chk("t1 busy after start",  32'(busy),      32'd1);
        chk("t1 first read",        32'(avm_read),  32'd1);
        chk("t1 first address",     avm_address,    32'h0);
        chk("t1 no pixel yet",      32'(pix_valid), 32'd0);
        tick();
        chk("t1 no pixel at rdv",   32'(pix_valid), 32'd0);
        tick();
        chk("t1 pixel after rdv",   32'(pix_valid), 32'd1);
        chk("t1 first pixel data",  32'(pix_data),  32'h0000C000);
        chk("t1 first pixel sop",   32'({pix_sop, pix_eop}), 32'd2);
        wait_done("t1", 200);
        check_frame("t1", 32'h0, 16, acc0, rx0, fd0);

        // 4a: empty frame.
        acc0 = acc_addr.size();
        pulse_start(32'h80, 13'd0);
        chk("t4 busy",            32'(busy),       32'd1);
        chk("t4 no done yet",     32'(frame_done), 32'd0);
        chk("t4 no read",         32'(avm_read),   32'd0);
        tick();
        chk("t4 done at +2",      32'(frame_done), 32'd1);
        chk("t4 busy cleared",    32'(busy),       32'd0);
        tick();
        chk("t4 done dropped",    32'(frame_done), 32'd0);
        chk("t4 zero reads",      32'(acc_addr.size() - acc0), 32'd0);

        // 4b: single-word frame.
        acc0 = acc_addr.size(); rx0 = rx_data.size(); fd0 = fd_cnt;
        pulse_start(32'h40, 13'd1);
        wait_done("t4b", 100);
        check_frame("t4b", 32'h40, 1, acc0, rx0, fd0);

        // 5: second start while busy is ignored.
        acc0 = acc_addr.size(); rx0 = rx_data.size(); fd0 = fd_cnt;
        pulse_start(32'h80, 13'd16);
        tick();
        tick();
        chk("t5 busy at restart", 32'(busy), 32'd1);
        pulse_start(32'h100, 13'd5);
        base = 32'h0; num = 13'd0;
        wait_done("t5", 200);
        check_frame("t5", 32'h80, 16, acc0, rx0, fd0);

        // 2: full frame, random stalls and random backpressure.
        acc0 = acc_addr.size(); rx0 = rx_data.size(); fd0 = fd_cnt;
        lat = 2; wr_pct = 30; rdy_mode = 1;
        pulse_start(32'h10, 13'd4096);
        wait_done("t2", 40000);
        check_frame("t2", 32'h10, 4096, acc0, rx0, fd0);
        chk("t2 address held in stall", 32'(stab_err), 32'd0);
        chk("t2 outstanding <= 8", 32'(max_out <= 8), 32'd1);
        wr_pct = 0; rdy_mode = 0;

        // 3: sink stalls mid-frame; credit caps reads at the FIFO depth.
        acc0 = acc_addr.size(); rx0 = rx_data.size(); fd0 = fd_cnt;
        lat = 3;
        pulse_start(32'h200, 13'd64);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            tick();
            if (rx_data.size() - rx0 >= 10) ok = 1'b1;
        end
        chk("t3 stream started", 32'(ok), 32'd1);
        rdy_mode = 2;
        repeat (100) tick();
        chk("t3 reads minus pops", 32'((acc_addr.size() - acc0) - (rx_data.size() - rx0)), 32'd8);
        chk("t3 read parked",     32'(avm_read),  32'd0);
        chk("t3 pixel held",      32'(pix_valid), 32'd1);
        rdy_mode = 0;
        wait_done("t3", 400);
        check_frame("t3", 32'h200, 64, acc0, rx0, fd0);

        // 6: reset with three reads in flight; late responses must vanish.
        acc0 = acc_addr.size(); rx0 = rx_data.size();
        lat = 8;
        pulse_start(32'h400, 13'd32);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (acc_addr.size() - acc0 >= 3) ok = 1'b1;
        end
        wr_pct = 100;
        rst = 1'b1;
        chk("t6 three in flight", 32'(acc_addr.size() - acc0), 32'd3);
        tick();
        tick();
        rst = 1'b0; wr_pct = 0;
        seen_v = 0; seen_b = 0; seen_r = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (pix_valid) seen_v++;
            if (busy)      seen_b++;
            if (avm_read)  seen_r++;
        end
        chk("t6 late rsp delivered", 32'(rsp_due.size()), 32'd0);
        chk("t6 no pixel after rst", 32'(seen_v), 32'd0);
        chk("t6 not busy after rst", 32'(seen_b), 32'd0);
        chk("t6 no read after rst",  32'(seen_r), 32'd0);
        chk("t6 nothing streamed",   32'(rx_data.size() - rx0), 32'd0);
        lat = 1;
        acc0 = acc_addr.size(); rx0 = rx_data.size(); fd0 = fd_cnt;
        pulse_start(32'h400, 13'd8);
        wait_done("t6", 100);
        check_frame("t6", 32'h400, 8, acc0, rx0, fd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
